idiv_int_div_iterative: RTL

- Iterative restoring integer divider; the inverse operation of the team's single-cycle multiplier.
- Sits beside the imul blocks and uses a latency-insensitive val/rdy request/response interface.
- Computes quotient and remainder one bit per cycle.
- Used by the processor's M-extension datapath and by standalone test harnesses.

---
 rtl/idiv_pkg.sv | 28 ++
 rtl/idiv_int_div_iterative_dpath.sv | 108 ++++++++++
 rtl/idiv_int_div_iterative.sv | 100 ++++++++++
 3 files changed

// File: rtl/idiv_pkg.sv
// Shared constants and bus payload types for the iterative integer divider.
// Optional signed mode is selected with the IDIV_INT_DIV_SIGNED_EN macro.
package idiv_pkg;

  localparam int unsigned IDIV_NBITS_DEFAULT = 32;
  localparam int unsigned ST_W               = 2;

  // FSM state encodings
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_CALC = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;
`ifdef IDIV_INT_DIV_SIGNED_EN
  localparam logic [ST_W-1:0] ST_SIGN = 2'd3;
`endif

  // Request payload: {dividend, divisor}
  typedef struct packed {
    logic [IDIV_NBITS_DEFAULT-1:0] dividend;
    logic [IDIV_NBITS_DEFAULT-1:0] divisor;
  } idiv_req_t;

  // Response payload: {quotient, remainder}
  typedef struct packed {
    logic [IDIV_NBITS_DEFAULT-1:0] quotient;
    logic [IDIV_NBITS_DEFAULT-1:0] remainder;
  } idiv_resp_t;

endpackage

// File: rtl/idiv_int_div_iterative_dpath.sv
// Restoring-divider datapath: R/Q/D registers, trial subtractor, iteration
// counter and (with IDIV_INT_DIV_SIGNED_EN) operand/result sign handling.
module idiv_int_div_iterative_dpath
  import idiv_pkg::*;
#(
  parameter int unsigned NBITS = IDIV_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
`ifdef IDIV_INT_DIV_SIGNED_EN
  input  logic             fix,
`endif
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             count_zero_c,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder
);

  localparam int unsigned CW = $clog2(NBITS) + 1;

  // R is conceptually NBITS+1 bits, but it always stays below D, so its top
  // bit is only ever non-zero in the shifted trial value and is not stored.
  logic [NBITS-1:0] r_q;
  logic [NBITS-1:0] q_q;
  logic [NBITS-1:0] d_q;
  logic [CW-1:0]    cnt_q;

  logic [NBITS:0]   r_sh;
  logic [NBITS:0]   t;
  logic [NBITS-1:0] q_ld;
  logic [NBITS-1:0] d_ld;

`ifdef IDIV_INT_DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic b_zero;
  logic sq_ld;
  logic sr_ld;
  logic sq_q;
  logic sr_q;

  // Operand magnitudes and result signs; divide-by-zero keeps the raw dividend
  always_comb begin
    a_neg  = dividend[NBITS-1];
    b_neg  = divisor[NBITS-1];
    b_zero = (divisor == '0);
    q_ld   = dividend;
    d_ld   = divisor;
    if (a_neg && !b_zero) q_ld = ~dividend + NBITS'(1);
    if (b_neg)            d_ld = ~divisor + NBITS'(1);
    sq_ld  = !b_zero && (a_neg ^ b_neg);
    sr_ld  = !b_zero && a_neg;
  end
`else
  assign q_ld = dividend;
  assign d_ld = divisor;
`endif

  // One restoring step: shift {R,Q} left and trial-subtract D
  assign r_sh = {r_q, q_q[NBITS-1]};
  assign t    = r_sh - {1'b0, d_q};

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
`ifdef IDIV_INT_DIV_SIGNED_EN
      sq_q  <= 1'b0;
      sr_q  <= 1'b0;
`endif
    end else if (load) begin
      r_q   <= '0;
      q_q   <= q_ld;
      d_q   <= d_ld;
      cnt_q <= CW'(NBITS);
`ifdef IDIV_INT_DIV_SIGNED_EN
      sq_q  <= sq_ld;
      sr_q  <= sr_ld;
`endif
    end else if (step) begin
      if (!t[NBITS]) begin
        r_q <= t[NBITS-1:0];
        q_q <= {q_q[NBITS-2:0], 1'b1};
      end else begin
        r_q <= r_sh[NBITS-1:0];
        q_q <= {q_q[NBITS-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
`ifdef IDIV_INT_DIV_SIGNED_EN
    end else if (fix) begin
      if (sq_q) q_q <= ~q_q + NBITS'(1);
      if (sr_q) r_q <= ~r_q + NBITS'(1);
`endif
    end
  end

  // High when the current step is the last one (counter lands on zero)
  assign count_zero_c = (cnt_q == CW'(1));
  assign quotient     = q_q;
  assign remainder    = r_q;

endmodule

// File: rtl/idiv_int_div_iterative.sv
// Iterative restoring integer divider with val/rdy request/response ports.
// One quotient bit per cycle; IDIV_INT_DIV_SIGNED_EN enables signed operands.
module idiv_int_div_iterative
  import idiv_pkg::*;
#(
  parameter int unsigned NBITS = IDIV_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*NBITS-1:0] resp_msg
);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_next;
  logic             load_c;
  logic             step_c;
  logic             count_zero_c;
  logic [NBITS-1:0] quotient;
  logic [NBITS-1:0] remainder;
`ifdef IDIV_INT_DIV_SIGNED_EN
  logic             fix_c;
`endif

  // State and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      state_q  <= state_next;
      req_rdy  <= (state_next == ST_IDLE);
      resp_val <= (state_next == ST_DONE);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state_q;
    load_c     = 1'b0;
    step_c     = 1'b0;
`ifdef IDIV_INT_DIV_SIGNED_EN
    fix_c      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_val && req_rdy) begin
          load_c     = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        step_c = 1'b1;
        if (count_zero_c) begin
`ifdef IDIV_INT_DIV_SIGNED_EN
          state_next = ST_SIGN;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef IDIV_INT_DIV_SIGNED_EN
      ST_SIGN: begin
        fix_c      = 1'b1;
        state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (resp_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  idiv_int_div_iterative_dpath #(
    .NBITS (NBITS)
  ) u_dpath (
    .clk          (clk),
    .reset        (reset),
    .load         (load_c),
    .step         (step_c),
`ifdef IDIV_INT_DIV_SIGNED_EN
    .fix          (fix_c),
`endif
    .dividend     (req_msg[2*NBITS-1:NBITS]),
    .divisor      (req_msg[NBITS-1:0]),
    .count_zero_c (count_zero_c),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  // Result registers drive the response payload directly
  assign resp_msg = {quotient, remainder};

endmodule
